// File: rtl/lcd_mode_sequencer.sv
// LCD timing controller: dot/line counters, STAT render mode, LY==LYC coincidence,
// VBLANK/STAT interrupt pulses and per-line OAM/fetch start strobes. All outputs registered.
module lcd_mode_sequencer #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       oam_start,
    output logic       xfer_start,
    output logic       line_done,
    output logic       vblank_irq,
    output logic       stat_irq
);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

    logic       running_r;
    logic [8:0] dot_r;
    logic [7:0] ly_r;
    mode_t      mode_r;
    logic       coincidence_r;
    logic       oam_start_r;
    logic       xfer_start_r;
    logic       line_done_r;
    logic       vblank_irq_r;
    logic       stat_irq_r;
    logic       stat_line_r;

    logic       start_s;
    logic [8:0] dot_next_s;
    logic [7:0] ly_next_s;
    mode_t      mode_next_s;
    logic       coincidence_next_s;
    logic       stat_line_next_s;

    // Counter next-state: restart at line 0/dot 0 on enable, hold at zero while disabled.
    always_comb begin
        start_s    = lcd_enable & ~running_r;
        dot_next_s = 9'd0;
        ly_next_s  = 8'd0;
        if (!lcd_enable || start_s) begin
            dot_next_s = 9'd0;
            ly_next_s  = 8'd0;
        end else if (dot_r == DOT_LAST) begin
            dot_next_s = 9'd0;
            ly_next_s  = (ly_r == LY_LAST) ? 8'd0 : ly_r + 8'd1;
        end else begin
            dot_next_s = dot_r + 9'd1;
            ly_next_s  = ly_r;
        end
    end

    // Mode FSM next state, decoded from the next-state position so mode and counters move together.
    always_comb begin
        mode_next_s = MODE_HBLANK;
        if (!lcd_enable) begin
            mode_next_s = MODE_HBLANK;
        end else if (ly_next_s >= LY_VIS) begin
            mode_next_s = MODE_VBLANK;
        end else if (dot_next_s < OAM_END) begin
            mode_next_s = MODE_OAM;
        end else if (dot_next_s < XFER_END) begin
            mode_next_s = MODE_XFER;
        end else begin
            mode_next_s = MODE_HBLANK;
        end
    end

    // STAT line precomputed from next-state values so stat_irq lands with the mode/coincidence it reflects.
    always_comb begin
        coincidence_next_s = lcd_enable & (ly_next_s == lyc);
        stat_line_next_s   = 1'b0;
        if (lcd_enable) begin
            stat_line_next_s = (stat_int_en[3] & coincidence_next_s)
                             | (stat_int_en[2] & (mode_next_s == MODE_OAM))
                             | (stat_int_en[1] & (mode_next_s == MODE_VBLANK))
                             | (stat_int_en[0] & (mode_next_s == MODE_HBLANK));
        end else begin
            stat_line_next_s = 1'b0;
        end
    end

    // Mode FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= MODE_HBLANK;
        end else begin
            mode_r <= mode_next_s;
        end
    end

    // Counters, strobes and interrupt registers; disable forces everything to its idle value.
    always_ff @(posedge clk) begin
        if (rst) begin
            running_r     <= 1'b0;
            dot_r         <= 9'd0;
            ly_r          <= 8'd0;
            coincidence_r <= 1'b0;
            oam_start_r   <= 1'b0;
            xfer_start_r  <= 1'b0;
            line_done_r   <= 1'b0;
            vblank_irq_r  <= 1'b0;
            stat_irq_r    <= 1'b0;
            stat_line_r   <= 1'b0;
        end else begin
            running_r     <= lcd_enable;
            dot_r         <= dot_next_s;
            ly_r          <= ly_next_s;
            coincidence_r <= coincidence_next_s;
            oam_start_r   <= lcd_enable & (mode_next_s == MODE_OAM) & (dot_next_s == 9'd0);
            xfer_start_r  <= lcd_enable & (mode_next_s == MODE_XFER) & (dot_next_s == OAM_END);
            line_done_r   <= lcd_enable & (dot_next_s == DOT_LAST);
            vblank_irq_r  <= lcd_enable & (ly_next_s == LY_VIS) & (dot_next_s == 9'd0);
            // Rising-edge detect against the previous line level blocks back-to-back sources.
            stat_irq_r    <= stat_line_next_s & ~stat_line_r;
            stat_line_r   <= stat_line_next_s;
        end
    end

    assign ly          = ly_r;
    assign dot         = dot_r;
    assign mode        = mode_r;
    assign coincidence = coincidence_r;
    assign oam_start   = oam_start_r;
    assign xfer_start  = xfer_start_r;
    assign line_done   = line_done_r;
    assign vblank_irq  = vblank_irq_r;
    assign stat_irq    = stat_irq_r;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Directed bench for lcd_mode_sequencer: line timing, full frame, coincidence, STAT blocking,
// disable/re-enable and mid-line reset, with hand-computed expectations.
module tb_lcd_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_int_en;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       coincidence;
    logic       oam_start;
    logic       xfer_start;
    logic       line_done;
    logic       vblank_irq;
    logic       stat_irq;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int vb_count   = 0;
    int stat_count = 0;
    int mode_err   = 0;
    bit chk_mode   = 1'b0;

    localparam int F = 70224;

    lcd_mode_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_enable  (lcd_enable),
        .lyc         (lyc),
        .stat_int_en (stat_int_en),
        .ly          (ly),
        .dot         (dot),
        .mode        (mode),
        .coincidence (coincidence),
        .oam_start   (oam_start),
        .xfer_start  (xfer_start),
        .line_done   (line_done),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one dot, sample 1 time unit after the edge, and keep running tallies.
    task automatic tick();
        logic [1:0] em;
        @(posedge clk);
        #1;
        cyc++;
        if (vblank_irq === 1'b1) vb_count++;
        if (stat_irq === 1'b1) stat_count++;
        if (chk_mode) begin
            if (ly >= 8'd144)      em = 2'd1;
            else if (dot < 9'd80)  em = 2'd2;
            else if (dot < 9'd252) em = 2'd3;
            else                   em = 2'd0;
            if (mode !== em) mode_err++;
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; lcd_enable = 1'b0; lyc = 8'hFF; stat_int_en = 4'b0000;
        tick(); tick();
        check_eq("rst_ly", ly, 0);
        check_eq("rst_dot", dot, 0);
        check_eq("rst_mode", mode, 0);
        check_eq("rst_coinc", coincidence, 0);
        check_eq("rst_pulses", {oam_start, xfer_start, line_done, vblank_irq, stat_irq}, 0);

        // Disabled: counters frozen, no STAT pulse even though HBLANK enable is set
        rst = 1'b0; stat_int_en = 4'b0011;
        tick(); tick();
        check_eq("dis_dot", dot, 0);
        check_eq("dis_mode", mode, 0);
        check_eq("dis_stat", stat_irq, 0);

        // Enable: cycle 0 is OAM with oam_start
        lcd_enable = 1'b1; cyc = -1; vb_count = 0; stat_count = 0; chk_mode = 1'b1;
        tick();
        check_eq("en_mode", mode, 2);
        check_eq("en_oam", oam_start, 1);
        check_eq("en_dot", dot, 0);
        check_eq("en_ly", ly, 0);
        run_to(79);
        check_eq("d79_mode", mode, 2);
        check_eq("d79_xfer", xfer_start, 0);
        tick();
        check_eq("d80_mode", mode, 3);
        check_eq("d80_xfer", xfer_start, 1);
        check_eq("d80_oam", oam_start, 0);
        run_to(251);
        check_eq("d251_mode", mode, 3);
        check_eq("d251_stat", stat_irq, 0);
        tick();
        check_eq("d252_mode", mode, 0);
        check_eq("d252_stat", stat_irq, 1);
        run_to(455);
        check_eq("d455_done", line_done, 1);
        tick();
        check_eq("l1_ly", ly, 1);
        check_eq("l1_dot", dot, 0);
        check_eq("l1_mode", mode, 2);
        check_eq("l1_oam", oam_start, 1);
        check_eq("l1_done", line_done, 0);

        // Full frame: VBLANK entry, HBLANK->VBLANK keeps STAT line high
        run_to(65663);
        check_eq("l143_ly", ly, 143);
        check_eq("l143_mode", mode, 0);
        check_eq("l143_vb", vblank_irq, 0);
        tick();
        check_eq("vb_ly", ly, 144);
        check_eq("vb_dot", dot, 0);
        check_eq("vb_mode", mode, 1);
        check_eq("vb_irq", vblank_irq, 1);
        check_eq("vb_stat", stat_irq, 0);
        check_eq("vb_oam", oam_start, 0);
        tick();
        check_eq("vb_irq_off", vblank_irq, 0);
        run_to(F - 1);
        check_eq("l153_ly", ly, 153);
        check_eq("l153_mode", mode, 1);
        check_eq("l153_done", line_done, 1);
        check_eq("frame_stat_pulses", stat_count, 144);
        check_eq("frame_vb_pulses", vb_count, 1);

        // Coincidence interrupt on line 5 of the second frame
        lyc = 8'd5; stat_int_en = 4'b1000;
        tick();
        check_eq("wrap_ly", ly, 0);
        check_eq("wrap_mode", mode, 2);
        check_eq("wrap_oam", oam_start, 1);
        check_eq("wrap_stat", stat_irq, 0);
        stat_count = 0;
        run_to(F + 5 * 456 - 1);
        check_eq("l4_coinc", coincidence, 0);
        tick();
        check_eq("l5_ly", ly, 5);
        check_eq("l5_coinc", coincidence, 1);
        check_eq("l5_stat", stat_irq, 1);
        run_to(F + 5 * 456 + 100);
        check_eq("l5_coinc_hold", coincidence, 1);
        check_eq("l5_one_pulse", stat_count, 1);
        lyc = 8'd6;
        tick();
        check_eq("lyc6_coinc", coincidence, 0);
        check_eq("lyc6_ly", ly, 5);
        run_to(F + 6 * 456);
        check_eq("l6_coinc", coincidence, 1);
        check_eq("l6_stat", stat_irq, 1);

        // Disable mid-transfer with HBLANK interrupt enabled: no pulse from the drop
        run_to(F + 7 * 456 + 100);
        stat_int_en = 4'b0001;
        run_to(F + 7 * 456 + 200);
        check_eq("pre_dis_mode", mode, 3);
        lcd_enable = 1'b0; stat_count = 0; vb_count = 0; chk_mode = 1'b0;
        tick();
        check_eq("off_ly", ly, 0);
        check_eq("off_dot", dot, 0);
        check_eq("off_mode", mode, 0);
        check_eq("off_coinc", coincidence, 0);
        check_eq("off_pulses", {oam_start, xfer_start, line_done, vblank_irq, stat_irq}, 0);
        tick(); tick(); tick();
        check_eq("off_frozen", dot, 0);
        check_eq("off_no_irq", stat_count + vb_count, 0);

        // Re-enable restarts at line 0 in OAM
        lcd_enable = 1'b1; cyc = -1; chk_mode = 1'b1;
        tick();
        check_eq("reen_mode", mode, 2);
        check_eq("reen_oam", oam_start, 1);
        check_eq("reen_ly", ly, 0);

        // Synchronous reset mid-transfer on line 2
        run_to(2 * 456 + 100);
        check_eq("pre_rst_mode", mode, 3);
        check_eq("pre_rst_ly", ly, 2);
        rst = 1'b1; chk_mode = 1'b0;
        tick();
        check_eq("mrst_ly", ly, 0);
        check_eq("mrst_dot", dot, 0);
        check_eq("mrst_mode", mode, 0);
        check_eq("mrst_pulses", {coincidence, oam_start, xfer_start, line_done, vblank_irq, stat_irq}, 0);
        rst = 1'b0; cyc = -1; chk_mode = 1'b1;
        tick();
        check_eq("rs_mode", mode, 2);
        check_eq("rs_oam", oam_start, 1);
        check_eq("rs_dot", dot, 0);
        run_to(80);
        check_eq("rs_xfer", xfer_start, 1);
        run_to(252);
        check_eq("rs_hblank", mode, 0);
        check_eq("rs_stat", stat_irq, 1);

        check_eq("mode_model", mode_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
